// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI follower endpoint.
// Frame sizes, TX fill word and MSB alignment helper.
package spi_pkg;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    localparam int FRAME_8 = 8;
    localparam int FRAME_16 = 16;
    localparam logic [15:0] TX_FILL = 16'hFFFF;

    // Place the leading bit of either frame size at bit 15.
    function automatic logic [15:0] align_msb(
        input logic [15:0] w,
        input logic        l16
    );
        return l16 ? w : {w[7:0], 8'h00};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an async pin with rise/fall pulses.
// Resets to 0 so a pin already low at reset release gives no fall.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_follower.sv
// SPI follower endpoint: oversampled pins, TX holding register,
// back-to-back 8/16-bit frames, overrun/underrun pulses.
module spi_follower
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpol,
    input  logic        cpha,
    input  logic        len,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [15:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        busy,
    output logic        overrun,
    output logic        underrun
);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk),
        .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
        .clk(clk), .rst_n(rst_n), .d(cs_n),
        .level(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
        .clk(clk), .rst_n(rst_n), .d(mosi),
        .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_sigs;
    assign unused_sigs = ^{sclk_s, cs_s, mosi_rise, mosi_fall};

    state_t      state;
    logic        cpol_q, cpha_q, len_q;
    logic [15:0] tx_sh, rx_sh, hold_q;
    logic        hold_full;
    logic [3:0]  bit_cnt;

    logic        lead, trail, smp_edge, sft_edge;
    logic        last_bit, done, do_load;
    logic        ld_len, ld_cpha, ld_fill;
    logic [15:0] ld_word, ld_al;

    always_comb begin
        lead  = cpol_q ? sclk_fall : sclk_rise;
        trail = cpol_q ? sclk_rise : sclk_fall;
        smp_edge = (state == ACTIVE) && (cpha_q ? trail : lead);
        // cpha=0: the trailing edge right after a reload must not shift
        sft_edge = (state == ACTIVE) && (cpha_q ? lead : trail)
                   && (cpha_q || bit_cnt != 4'd0);
        last_bit = bit_cnt == (len_q ? 4'(FRAME_16 - 1)
                                     : 4'(FRAME_8 - 1));
        done     = smp_edge && last_bit;
        do_load  = (state == IDLE) ? cs_fall : (done && !cs_rise);
        ld_len   = (state == IDLE) ? len : len_q;
        ld_cpha  = (state == IDLE) ? cpha : cpha_q;
        ld_word  = TX_FILL;
        ld_fill  = 1'b1;
        if (hold_full) begin
            ld_word = hold_q;
            ld_fill = 1'b0;
        end else if (tx_valid) begin
            ld_word = tx_data;
            ld_fill = 1'b0;
        end
        ld_al = align_msb(ld_word, ld_len);
    end

    assign tx_ready = !hold_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            len_q     <= 1'b0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            hold_q    <= '0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            miso      <= 1'b1;
            miso_oe   <= 1'b0;
            busy      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (tx_valid && !hold_full) begin
                hold_q    <= tx_data;
                hold_full <= 1'b1;
            end
            if (sft_edge) begin
                miso  <= tx_sh[15];
                tx_sh <= {tx_sh[14:0], 1'b0};
            end
            if (smp_edge) begin
                rx_sh   <= {rx_sh[14:0], mosi_s};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (done) begin
                rx_data  <= len_q ? {rx_sh[14:0], mosi_s}
                                  : {8'h00, rx_sh[6:0], mosi_s};
                rx_valid <= 1'b1;
                overrun  <= rx_valid && !rx_ready;
                bit_cnt  <= '0;
            end
            unique case (state)
                IDLE: if (cs_fall) begin
                    cpol_q  <= cpol;
                    cpha_q  <= cpha;
                    len_q   <= len;
                    busy    <= 1'b1;
                    miso_oe <= 1'b1;
                    state   <= ACTIVE;
                end
                ACTIVE: if (cs_rise) begin
                    busy    <= 1'b0;
                    miso_oe <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Bypass or fill load also cancels a same-cycle capture.
            if (do_load) begin
                tx_sh     <= ld_cpha ? ld_al : {ld_al[14:0], 1'b0};
                miso      <= ld_al[15];
                bit_cnt   <= '0;
                hold_full <= 1'b0;
                underrun  <= ld_fill;
            end
        end
    end

endmodule

// File: tb/tb_spi_follower.sv
// Directed bench for spi_follower with an rx scoreboard queue.
// Leader model drives pins at clk negedges.
module tb_spi_follower;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpol = 1'b0, cpha = 1'b0, len = 1'b0;
    logic        sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic        miso, miso_oe;
    logic [15:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b1;
    logic        busy, overrun, underrun;

    int checks = 0, failures = 0;
    int n_ovr = 0, n_udr = 0;
    logic busy_d = 1'b0;
    logic [15:0] exp_q[$];
    logic [31:0] mi;

    always #5 clk = ~clk;

    spi_follower #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpol(cpol), .cpha(cpha), .len(len),
        .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .overrun(overrun), .underrun(underrun)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: consumes rx words and counts flag pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (overrun) n_ovr++;
            if (underrun && !busy_d) n_udr++;
            if (rx_valid && rx_ready) begin
                chk("rx_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0)
                    chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
        busy_d = busy;
    end

    task automatic set_mode(input logic p, input logic h, input logic l);
        cpol = p;
        cpha = h;
        len  = l;
        sclk = p;
        repeat (4) @(negedge clk);
    endtask

    task automatic tx_push(input logic [15:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic xfer(input int nbits, input logic [31:0] mo,
                        output logic [31:0] got);
        got = '0;
        @(negedge clk);
        cs_n = 1'b0;
        if (!cpha) mosi = mo[nbits-1];
        repeat (HALF) @(negedge clk);
        chk("busy_in_frame", 32'(busy), 32'd1);
        chk("oe_in_frame", 32'(miso_oe), 32'd1);
        for (int i = nbits - 1; i >= 0; i--) begin
            sclk = ~sclk;
            if (cpha) mosi = mo[i];
            else got = {got[30:0], miso};
            repeat (HALF) @(negedge clk);
            sclk = ~sclk;
            if (cpha) got = {got[30:0], miso};
            else if (i > 0) mosi = mo[i-1];
            repeat (HALF) @(negedge clk);
        end
        cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 200 && exp_q.size() != 0; k++)
            @(negedge clk);
        chk(nm, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_miso"}, 32'(miso), 32'd1);
        chk({nm, "_oe"}, 32'(miso_oe), 32'd0);
        chk({nm, "_tx_ready"}, 32'(tx_ready), 32'd1);
        chk({nm, "_rx_data"}, 32'(rx_data), 32'd0);
        chk({nm, "_rx_valid"}, 32'(rx_valid), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset("rst");

        // Mode 0, 8-bit, preloaded 0xA5
        set_mode(1'b0, 1'b0, 1'b0);
        tx_push(16'h00A5);
        chk("t1_tx_ready", 32'(tx_ready), 32'd0);
        n_udr = 0; n_ovr = 0;
        exp_q.push_back(16'h003C);
        xfer(8, 32'h3C, mi);
        chk("t1_miso", mi, 32'hA5);
        drain("t1_drain");
        chk("t1_underrun", n_udr, 0);
        chk("t1_overrun", n_ovr, 0);
        chk("t1_tx_ready_after", 32'(tx_ready), 32'd1);

        // Mode 3, 16-bit
        set_mode(1'b1, 1'b1, 1'b1);
        tx_push(16'h1234);
        n_udr = 0;
        exp_q.push_back(16'hBEEF);
        xfer(16, 32'hBEEF, mi);
        chk("t2_miso", mi, 32'h1234);
        drain("t2_drain");
        chk("t2_underrun", n_udr, 0);

        // No TX word: fill and underrun
        set_mode(1'b0, 1'b0, 1'b0);
        n_udr = 0;
        exp_q.push_back(16'h0055);
        xfer(8, 32'h55, mi);
        chk("t3_miso", mi, 32'hFF);
        drain("t3_drain");
        chk("t3_underrun", n_udr, 1);

        // Back-to-back frames in one CS, consumer stalled
        rx_ready = 1'b0;
        tx_push(16'h00AA);
        n_ovr = 0; n_udr = 0;
        fork
            xfer(16, 32'h1122, mi);
            begin
                repeat (40) @(negedge clk);
                tx_push(16'h00BB);
            end
        join
        chk("t4_miso", mi, 32'hAABB);
        chk("t4_overrun", n_ovr, 1);
        chk("t4_underrun", n_udr, 0);
        chk("t4_rx_valid", 32'(rx_valid), 32'd1);
        exp_q.push_back(16'h0022);
        rx_ready = 1'b1;
        drain("t4_drain");

        // Abort after 5 bits, then a full frame
        n_udr = 0;
        xfer(5, 32'h16, mi);
        chk("t5_rx_valid", 32'(rx_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_oe", 32'(miso_oe), 32'd0);
        chk("t5_underrun", n_udr, 1);
        tx_push(16'h003C);
        exp_q.push_back(16'h0081);
        xfer(8, 32'h81, mi);
        chk("t5_miso", mi, 32'h3C);
        drain("t5_drain");

        // Reset mid-frame, then mode 1
        tx_push(16'h0000);
        fork
            xfer(8, 32'hF0, mi);
            begin
                repeat (30) @(negedge clk);
                tx_push(16'h005A);
                repeat (8) @(negedge clk);
                chk("t6_pre_tx_ready", 32'(tx_ready), 32'd0);
                chk("t6_pre_miso", 32'(miso), 32'd0);
                rst_n = 1'b0;
                #1;
                chk_reset("t6_rst");
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                repeat (20) @(negedge clk);
                chk("t6_no_restart", 32'(busy), 32'd0);
            end
        join
        set_mode(1'b0, 1'b1, 1'b0);
        tx_push(16'h0096);
        exp_q.push_back(16'h00C3);
        xfer(8, 32'hC3, mi);
        chk("t6_miso", mi, 32'h96);
        drain("t6_drain");

        chk("final_queue", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
